qspi_target: RTL and testbench
==============================

# qspi_target

Synthesizable quad-SPI memory responder: the far end of the chip's QSPI flash/PSRAM port. It decodes quad-mode read (0xEB) and write (0x38) transactions from the on-chip `qspi` controller and serves them from an internal byte array. It is used as the attached-memory model in system benches and as on-FPGA emulated PSRAM/ROM. One instance serves one chip select. The serial clock is the system clock, because the chip exports `clk` as the SPI clock.

## Interface
Parameters:
- DEPTH, 256: bytes of backing store; must be a power of 2. AW = $clog2(DEPTH).
- DUMMY, 6: wait cycles between the last address nibble and the first read data nibble; legal range 1..15.
- READONLY, 0: when 1, serial writes are decoded but never stored (flash/ROM emulation).

Ports:
- clk  in  1  system clock, also the SPI clock; all sampling and driving happens on the rising edge
- reset  in  1  synchronous, active-high
- cs_n  in  1  chip select, active low
- sio_in  in  4  quad data from the host
- sio_out  out  4  quad data to the host
- sio_oe  out  1  high while the target drives sio_out
- ld_we  in  1  backdoor byte write strobe (bench/FPGA preload)
- ld_addr  in  AW  backdoor address
- ld_data  in  8  backdoor data
- busy  out  1  high when state is not IDLE

## Operation
- Edge index k counts rising edges with cs_n sampled low, starting at k=0.
- Edges 0–1 carry the command, high nibble first.
- Edges 2–7 carry the 24-bit address, MSB nibble first.
- Only addr[AW-1:0] is kept. The address increments once per byte, modulo DEPTH.
- States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
  - IDLE→CMD on cs_n low.
  - CMD→ADDR on 0xEB or 0x38; any other command goes to IGNORE.
  - ADDR→DUMMY (read) or ADDR→WDATA (write) after 6 nibbles.
  - DUMMY→RDATA after DUMMY edges.
- cs_n sampled high in any state: go to IDLE, clear counters, deassert sio_oe. This takes priority over everything else.
- Read: nibble i is mem[addr+i/2][7:4] for even i and [3:0] for odd i. Reading is continuous until cs_n rises.
- Write: an even data nibble latches the high half. An odd data nibble completes the byte, writes mem[addr], then increments addr. A half byte pending at cs_n rise is discarded.
- With READONLY=1 the write sequence runs but memory is unchanged.
- IGNORE: sio_oe=0 and the state is held until cs_n rises.
- Backdoor: ld_we writes mem[ld_addr] in any state. If it collides with a serial write to the same address in the same cycle, the backdoor write wins.
- Memory is read combinationally. Memory contents are not affected by reset.

## Timing
- Reset values: state IDLE, sio_oe 0, sio_out 4'h0, busy 0, armed 0.
- armed: cleared by reset and set when cs_n is sampled high. CMD is entered only when armed=1.
  - A transaction already in progress when reset is released is ignored until cs_n rises.
- Read data:
  - sio_out and sio_oe are registered. Nibble 0 is updated at edge 7+DUMMY and visible from then on, so the host samples it at edge 8+DUMMY. Nibble i is visible after edge 7+DUMMY+i.
  - sio_oe rises at edge 7+DUMMY. It falls on the edge at which cs_n is sampled high.
- Write data: byte j is stored on edge 9+2j. It is readable by a transaction that starts on the next cs_n low.
- Address wrap: after DEPTH-1 the next byte is 0, with no gap cycle.
- busy is registered and follows state with 0 cycles of lag relative to the state register.

## Structure
- Package qspi_target_pkg:
  - CMD_QREAD=8'hEB and CMD_QWRITE=8'h38.
  - State enum, 3 bits.
  - ADDR_NIBBLES=6.
- Sub-module qspi_target_mem:
  - DEPTH×8 array, one combinational read port, two write ports (serial and backdoor) with the backdoor-wins rule.
- Top level contains the state machine, nibble/dummy counters, address register and output registers. Estimated 200–300 lines total.

## Test plan
- Write then read:
  - Preload nothing. Send 38 000010 A5 3C, then raise cs_n.
  - Send EB 000010 followed by 6 dummy edges.
  - Host samples A,5,3,C at edges 14–17, with sio_oe high from edge 13.
- Wrap-around:
  - With DEPTH=256, backdoor-load mem[FF]=11 and mem[00]=22.
  - Read EB 0000FF and expect nibbles 1,1,2,2.
  - Also check that address FFFFFF aliases to FF.
- Unknown command: send 9F followed by 20 edges. sio_oe stays 0 and memory is unchanged.
- Early cs_n: send 38 000020 then nibbles B,7,C, and raise cs_n. Expect mem[20]=B7 and mem[21] unchanged.
- Reset mid-read:
  - Assert reset during RDATA, release it with cs_n still low. sio_oe is 0 until cs_n rises.
  - A following EB transaction returns correct data.
- READONLY=1 and collision:
  - With READONLY=1, a serial write leaves memory unchanged.
  - With READONLY=0, serial and backdoor writes to the same address in one cycle leave the ld_data value in memory.

Source files
------------

// File: rtl/qspi_target_pkg.sv
// Shared definitions for the quad-SPI memory responder: command opcodes,
// address framing and the transaction state encoding.
package qspi_target_pkg;

  localparam logic [7:0]  CMD_QREAD    = 8'hEB;
  localparam logic [7:0]  CMD_QWRITE   = 8'h38;
  localparam int unsigned ADDR_NIBBLES = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DUMMY  = 3'd3,
    S_RDATA  = 3'd4,
    S_WDATA  = 3'd5,
    S_IGNORE = 3'd6
  } state_e;

endpackage

// File: rtl/qspi_target_mem.sv
// Byte-wide backing store: one combinational read port, a serial write port
// and a backdoor write port that takes precedence on an address collision.
module qspi_target_mem
  import qspi_target_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          s_we,
  input  logic [AW-1:0] s_addr,
  input  logic [7:0]    s_data,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data
);

  logic [7:0] mem_q [DEPTH];
  logic       s_blocked_s;

  assign rd_data     = mem_q[rd_addr];
  assign s_blocked_s = ld_we && (ld_addr == s_addr);

  // Contents survive reset; the backdoor wins when both ports hit one byte
  always_ff @(posedge clk) begin
    if (s_we && !s_blocked_s) begin
      mem_q[s_addr] <= s_data;
    end
    if (ld_we) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

endmodule

// File: rtl/qspi_target.sv
// Quad-SPI memory responder serving 0xEB quad reads and 0x38 quad writes
// from an internal byte array; the system clock doubles as the SPI clock.
module qspi_target
  import qspi_target_pkg::*;
#(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned DUMMY    = 6,
  parameter bit          READONLY = 1'b0,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs_n,
  input  logic [3:0]    sio_in,
  output logic [3:0]    sio_out,
  output logic          sio_oe,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic          busy
);

  localparam logic [3:0] ADDR_LAST  = 4'(ADDR_NIBBLES - 32'd1);
  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY - 32'd1);
  localparam logic       WR_ALLOW   = ~READONLY;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    hi_q, hi_d;
  logic          rd_q, rd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          armed_q, armed_d;
  logic [3:0]    sio_out_q, sio_out_d;
  logic          sio_oe_q, sio_oe_d;
  logic          busy_q;

  logic          wr_en_s;
  logic [7:0]    wr_data_s;
  logic [7:0]    rd_byte_s;
  logic [7:0]    cmd_s;

  assign cmd_s   = {hi_q, sio_in};
  assign sio_out = sio_out_q;
  assign sio_oe  = sio_oe_q;
  assign busy    = busy_q;

  qspi_target_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rd_addr (addr_q),
    .rd_data (rd_byte_s),
    .s_we    (wr_en_s),
    .s_addr  (addr_q),
    .s_data  (wr_data_s),
    .ld_we   (ld_we),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  // Next-state, counters, address assembly and output data selection
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    hi_d      = hi_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    armed_d   = armed_q;
    sio_out_d = sio_out_q;
    sio_oe_d  = sio_oe_q;
    wr_en_s   = 1'b0;
    wr_data_s = {hi_q, sio_in};

    if (cs_n) begin
      state_d   = S_IDLE;
      cnt_d     = 4'd0;
      phase_d   = 1'b0;
      hi_d      = 4'h0;
      rd_d      = 1'b0;
      addr_d    = '0;
      armed_d   = 1'b1;
      sio_out_d = 4'h0;
      sio_oe_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A select already low when reset released is not a valid frame
          if (armed_q) begin
            state_d = S_CMD;
            hi_d    = sio_in;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CMD: begin
          cnt_d = 4'd0;
          if (cmd_s == CMD_QREAD) begin
            state_d = S_ADDR;
            rd_d    = 1'b1;
          end else if (cmd_s == CMD_QWRITE) begin
            state_d = S_ADDR;
            rd_d    = 1'b0;
          end else begin
            state_d = S_IGNORE;
          end
        end
        S_ADDR: begin
          addr_d = (addr_q << 3'd4) | AW'(sio_in);
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = 4'd0;
            phase_d = 1'b0;
            state_d = rd_q ? S_DUMMY : S_WDATA;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_DUMMY: begin
          if (cnt_q == DUMMY_LAST) begin
            state_d   = S_RDATA;
            cnt_d     = 4'd0;
            phase_d   = 1'b1;
            sio_out_d = rd_byte_s[7:4];
            sio_oe_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_RDATA: begin
          if (phase_q) begin
            sio_out_d = rd_byte_s[3:0];
            addr_d    = addr_q + AW'(1'b1);
            phase_d   = 1'b0;
          end else begin
            sio_out_d = rd_byte_s[7:4];
            phase_d   = 1'b1;
          end
        end
        S_WDATA: begin
          if (phase_q) begin
            wr_en_s = WR_ALLOW;
            addr_d  = addr_q + AW'(1'b1);
            phase_d = 1'b0;
          end else begin
            hi_d    = sio_in;
            phase_d = 1'b1;
          end
        end
        S_IGNORE: begin
          state_d = S_IGNORE;
        end
        default: begin
          state_d  = S_IDLE;
          sio_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      phase_q   <= 1'b0;
      hi_q      <= 4'h0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      armed_q   <= 1'b0;
      sio_out_q <= 4'h0;
      sio_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      hi_q      <= hi_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      armed_q   <= armed_d;
      sio_out_q <= sio_out_d;
      sio_oe_q  <= sio_oe_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_qspi_target.sv
// Bench for qspi_target: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an edge-index memory model.
module tb_qspi_target;

  localparam int DEPTH = 256;
  localparam int DUMMY = 6;

  logic       clk = 1'b0;
  logic       reset, cs_n, ld_we;
  logic [3:0] sio_in;
  logic [7:0] ld_addr, ld_data;
  logic [3:0] out_rw, out_ro;
  logic       oe_rw, oe_ro, busy_rw, busy_ro;

  always #5 clk = ~clk;

  qspi_target #(.DEPTH(DEPTH), .DUMMY(DUMMY), .READONLY(1'b0)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .sio_in(sio_in), .sio_out(out_rw),
    .sio_oe(oe_rw), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy_rw));

  qspi_target #(.DEPTH(DEPTH), .DUMMY(DUMMY), .READONLY(1'b1)) dut_ro (
    .clk(clk), .reset(reset), .cs_n(cs_n), .sio_in(sio_in), .sio_out(out_ro),
    .sio_oe(oe_ro), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy_ro));

  int checks = 0;
  int errors = 0;
  bit rand_ld = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_rw [DEPTH];
  logic [7:0]  m_ro [DEPTH];
  int          k = 0;
  bit          armed = 1'b0;
  int          mode = 0;              // 1 read, 2 write, 3 ignored
  logic [3:0]  cmd_hi, wr_hi;
  logic [23:0] base24;
  logic [3:0]  exp_out_rw = 4'h0, exp_out_ro = 4'h0;
  logic        exp_oe = 1'b0, exp_busy = 1'b0;

  always @(posedge clk) begin
    int i, a;
    #1;
    if (reset) begin
      exp_oe = 1'b0; exp_out_rw = 4'h0; exp_out_ro = 4'h0; exp_busy = 1'b0;
      armed = 1'b0; k = 0;
    end else if (cs_n) begin
      exp_oe = 1'b0; exp_out_rw = 4'h0; exp_out_ro = 4'h0; exp_busy = 1'b0;
      armed = 1'b1; k = 0;
    end else if (!armed) begin
      exp_oe = 1'b0; exp_busy = 1'b0;
    end else begin
      exp_busy = 1'b1;
      if (k == 0) begin
        cmd_hi = sio_in; base24 = 24'h0; mode = 0;
      end else if (k == 1) begin
        if ({cmd_hi, sio_in} == 8'hEB)      mode = 1;
        else if ({cmd_hi, sio_in} == 8'h38) mode = 2;
        else                                mode = 3;
      end else if (k <= 7) begin
        base24 = {base24[19:0], sio_in};
      end else if (mode == 1 && k >= 7 + DUMMY) begin
        i = k - 7 - DUMMY;
        a = (int'(base24) + i / 2) % DEPTH;
        exp_out_rw = (i % 2 == 0) ? m_rw[a][7:4] : m_rw[a][3:0];
        exp_out_ro = (i % 2 == 0) ? m_ro[a][7:4] : m_ro[a][3:0];
        exp_oe = 1'b1;
      end else if (mode == 2) begin
        i = k - 8;
        if (i % 2 == 0) begin
          wr_hi = sio_in;
        end else begin
          a = (int'(base24) + i / 2) % DEPTH;
          m_rw[a] = {wr_hi, sio_in};
        end
      end
      k++;
    end
    if (ld_we) begin
      m_rw[ld_addr] = ld_data;
      m_ro[ld_addr] = ld_data;
    end
    chk("oe_rw",   {7'h0, oe_rw},   {7'h0, exp_oe});
    chk("oe_ro",   {7'h0, oe_ro},   {7'h0, exp_oe});
    chk("busy_rw", {7'h0, busy_rw}, {7'h0, exp_busy});
    chk("busy_ro", {7'h0, busy_ro}, {7'h0, exp_busy});
    chk("out_rw",  {4'h0, out_rw},  {4'h0, exp_out_rw});
    chk("out_ro",  {4'h0, out_ro},  {4'h0, exp_out_ro});
  end

  // ---------------- stimulus helpers ----------------
  logic [3:0] cap_rw [16];
  logic [3:0] cap_ro [16];
  logic       cap_oe [16];
  logic       oe_pre;
  logic [3:0] wnib [16];

  task automatic step(input logic csn, input logic [3:0] nib);
    @(negedge clk);
    cs_n = csn;
    sio_in = nib;
    if (rand_ld) begin
      ld_we   = ($urandom_range(0, 7) == 0);
      ld_addr = 8'($urandom);
      ld_data = 8'($urandom);
    end else begin
      ld_we = 1'b0;
    end
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
    step(1'b0, cmd[7:4]);
    step(1'b0, cmd[3:0]);
    for (int n = 0; n < 6; n++) step(1'b0, addr[23-4*n -: 4]);
  endtask

  task automatic read_txn(input logic [23:0] addr, input int n);
    step(1'b1, 4'h0);
    send_hdr(8'hEB, addr);
    repeat (DUMMY - 1) step(1'b0, 4'($urandom));
    @(posedge clk); #1; oe_pre = oe_rw;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 4'($urandom));
      @(posedge clk); #1;
      cap_rw[i] = out_rw; cap_ro[i] = out_ro; cap_oe[i] = oe_rw;
    end
    step(1'b1, 4'h0);
  endtask

  task automatic write_txn(input logic [23:0] addr, input int n);
    step(1'b1, 4'h0);
    send_hdr(8'h38, addr);
    for (int i = 0; i < n; i++) step(1'b0, wnib[i]);
    step(1'b1, 4'h0);
  endtask

  task automatic check_nibs(input string name, input int n,
                            input logic [15:0] exp_rw, input logic [15:0] exp_ro);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_rw%0d", name, i), {4'h0, cap_rw[i]}, {4'h0, exp_rw[15-4*i -: 4]});
      chk($sformatf("%s_ro%0d", name, i), {4'h0, cap_ro[i]}, {4'h0, exp_ro[15-4*i -: 4]});
      chk($sformatf("%s_oe%0d", name, i), {7'h0, cap_oe[i]}, 8'h01);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0]  cmd;
    logic [23:0] a;
    int          kind;
    reset = 1'b1; cs_n = 1'b1; sio_in = 4'h0;
    ld_we = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_oe",   {7'h0, oe_rw},   8'h00);
    chk("reset_out",  {4'h0, out_rw},  8'h00);
    chk("reset_busy", {7'h0, busy_rw}, 8'h00);
    @(negedge clk); reset = 1'b0;

    // Known contents everywhere: byte i holds i ^ 5A
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 4'h0);
      ld_we = 1'b1; ld_addr = 8'(i); ld_data = 8'(i) ^ 8'h5A;
    end
    step(1'b1, 4'h0);

    // Write A5 3C at 0x10, read it back
    wnib[0] = 4'hA; wnib[1] = 4'h5; wnib[2] = 4'h3; wnib[3] = 4'hC;
    write_txn(24'h000010, 4);
    read_txn(24'h000010, 4);
    chk("rd_oe_before", {7'h0, oe_pre}, 8'h00);
    check_nibs("wr_rd", 4, 16'hA53C, 16'h4A4B);

    // Address wrap and high-address aliasing
    step(1'b1, 4'h0); ld_we = 1'b1; ld_addr = 8'hFF; ld_data = 8'h11;
    step(1'b1, 4'h0); ld_we = 1'b1; ld_addr = 8'h00; ld_data = 8'h22;
    step(1'b1, 4'h0);
    read_txn(24'h0000FF, 4);
    check_nibs("wrap", 4, 16'h1122, 16'h1122);
    read_txn(24'hFFFFFF, 4);
    check_nibs("alias", 4, 16'h1122, 16'h1122);

    // Unknown command is ignored
    step(1'b1, 4'h0);
    step(1'b0, 4'h9); step(1'b0, 4'hF);
    repeat (20) step(1'b0, 4'($urandom));
    step(1'b1, 4'h0);
    read_txn(24'h000010, 4);
    check_nibs("unk", 4, 16'hA53C, 16'h4A4B);

    // Half byte pending at deselect is dropped
    wnib[0] = 4'hB; wnib[1] = 4'h7; wnib[2] = 4'hC;
    write_txn(24'h000020, 3);
    read_txn(24'h000020, 4);
    check_nibs("early", 4, 16'hB77B, 16'h7A7B);

    // Reset during read data, select held low afterwards
    step(1'b1, 4'h0);
    send_hdr(8'hEB, 24'h000010);
    repeat (DUMMY + 2) step(1'b0, 4'h0);
    step(1'b0, 4'h0); reset = 1'b1;
    step(1'b0, 4'h0);
    step(1'b0, 4'h0); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'hA);
      @(posedge clk); #1;
      chk("rst_oe", {7'h0, oe_rw}, 8'h00);
    end
    step(1'b1, 4'h0);
    read_txn(24'h000010, 2);
    check_nibs("post_rst", 2, 16'hA500, 16'h4A00);

    // Serial and backdoor write to the same byte in one cycle
    step(1'b1, 4'h0);
    send_hdr(8'h38, 24'h000040);
    step(1'b0, 4'h1);
    step(1'b0, 4'h2); ld_we = 1'b1; ld_addr = 8'h40; ld_data = 8'h99;
    step(1'b0, 4'h3);
    step(1'b0, 4'h4);
    step(1'b1, 4'h0);
    read_txn(24'h000040, 4);
    check_nibs("collide", 4, 16'h9934, 16'h991B);

    // Randomized traffic with background backdoor writes and resets
    rand_ld = 1'b1;
    repeat (80) begin
      kind = $urandom_range(0, 9);
      repeat ($urandom_range(1, 3)) step(1'b1, 4'($urandom));
      a = 24'($urandom);
      if (kind == 9) begin
        send_hdr(8'hEB, a);
        repeat (DUMMY + 2) step(1'b0, 4'($urandom));
        reset = 1'b1;
        step(1'b0, 4'($urandom));
        step(1'b0, 4'($urandom));
        reset = 1'b0;
        repeat (3) step(1'b0, 4'($urandom));
      end else begin
        cmd = (kind < 4) ? 8'hEB : (kind < 8) ? 8'h38 : 8'($urandom);
        send_hdr(cmd, a);
        repeat ($urandom_range(0, DUMMY + 20)) step(1'b0, 4'($urandom));
      end
    end
    rand_ld = 1'b0;
    repeat (3) step(1'b1, 4'h0);
    @(posedge clk); #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
